mor1kx_branch_predictor_gshare: RTL and testbench
=================================================

Name: mor1kx_branch_predictor_gshare

Overview:
- Decode-stage conditional-branch direction predictor that sits alongside the branch-prediction wrapper as its table-based predictor.
- It produces predicted_flag_o for the wrapper and consumes the resolved flag from execute/ctrl to train itself.
- It holds a pattern history table (PHT) of 2-bit saturating counters, indexed by PC bits XOR a global history register (GHR).
- After reset it runs a table-initialisation walk before it predicts from the PHT.

Parameters:
- OPTION_OPERAND_WIDTH, 32, width of brn_pc_i.
- GSHARE_BITS_NUM, 10, GHR length and PHT index width; the PHT has 2^GSHARE_BITS_NUM entries. Legal range 2..(OPTION_OPERAND_WIDTH-2).

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- op_bf_i  in  1  decode insn is l.bf.
- op_bnf_i  in  1  decode insn is l.bnf.
- brn_pc_i  in  OPTION_OPERAND_WIDTH  PC of the decode insn.
- padv_decode_i  in  1  decode stage advances this cycle.
- prev_op_brcond_i  in  1  insn in decode-execute is a conditional branch.
- execute_op_bf_i  in  1  resolving branch is l.bf.
- execute_op_bnf_i  in  1  resolving branch is l.bnf.
- flag_i  in  1  real SR[F] for the resolving branch.
- predicted_flag_o  out  1  predicted flag for the decode insn.
- init_done_o  out  1  high once the PHT walk has completed.

Behaviour:
- Reset (rst=0, async):
  - GHR=0, saved index=0, walk pointer=0, FSM=INIT, init_done_o=0.
  - PHT contents are undefined until the walk completes.
- FSM:
  - INIT: writes 2'b01 (weakly not taken) to PHT[ptr] each cycle and increments ptr. When ptr==2^N-1 is written, moves to RUN and sets init_done_o=1 on the next cycle. The walk takes 2^N cycles.
  - RUN: terminal state; left only by reset. Reset asserted mid-walk restarts the walk from 0.
- Index: idx = brn_pc_i[N+1:2] XOR GHR.
- Prediction (combinational from registered PHT):
  - taken = PHT[idx][1] in RUN; taken = 0 in INIT.
  - predicted_flag_o = op_bf_i ? taken : (op_bnf_i ? ~taken : 0).
  - Reset value of predicted_flag_o: 0 with op_bf_i=1 or no branch; 1 with op_bnf_i=1.
- Index capture: when padv_decode_i & (op_bf_i|op_bnf_i), idx is registered as saved_idx. This is the index the same branch trains when it resolves one stage later.
- Training fires when prev_op_brcond_i & padv_decode_i & RUN:
  - real_taken = execute_op_bf_i ? flag_i : ~flag_i.
  - PHT[saved_idx] saturating update: +1 if real_taken (max 2'b11), -1 otherwise (min 2'b00).
  - GHR <= {GHR[N-2:0], real_taken}.
  - Prediction and training are independent in the same cycle. The training write lands at the clock edge.
  - Training requests during INIT are dropped; GHR is not updated.
- Same cycle, idx==saved_idx: read-before-write (stale value) unless the bypass below is enabled.
- GHR shifting affects the idx of the next cycle only.
- Stall (padv_decode_i=0): no capture, no training; all state holds.

Optional Feature:
- MOR1KX_GSHARE_BYPASS_EN:
  - Defined: when training and lookup target the same entry in one cycle, taken comes from the updated counter value. The lookup idx uses the old GHR.
  - Undefined: taken comes from the stale stored value.

Decomposition:
- Package mor1kx_bp_pkg:
  - Counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - FSM state encodings INIT/RUN.
  - Saturating-update function.
- Sub-module mor1kx_gshare_pht:
  - 2^N x 2 storage with one combinational read port and one write port.
  - Owns the INIT walk and the write mux between walk and training.

Test Plan:
- Reset, N=4 -> init_done_o low for exactly 16 cycles after rst deasserts, then high; op_bf_i=1 during INIT -> predicted_flag_o=0; op_bnf_i=1 -> predicted_flag_o=1.
- After init, l.bf at PC 0x40 resolves taken (flag_i=1) twice -> entry at idx 0x0 ^ GHR progresses 01->10->11; GHR=0b0011; next l.bf whose idx hits that entry -> predicted_flag_o=1.
- Train one entry to 11, then apply 3 more taken resolves -> stays 11; then 4 not-taken resolves -> 00, never wraps to 11.
- Hold padv_decode_i=0 with prev_op_brcond_i=1 for 5 cycles -> PHT and GHR unchanged; release -> exactly one update.
- Same-cycle lookup and update of one entry at 01 with real_taken=1 -> predicted taken=0 without MOR1KX_GSHARE_BYPASS_EN, 1 with it.
- Assert rst at walk pointer 7 -> init_done_o=0; walk restarts and completes 16 cycles after release.

Source files
------------

// File: rtl/mor1kx_bp_pkg.sv
// ---------------------------------------------------------------------------
// mor1kx_bp_pkg
// Shared definitions for the gshare branch direction predictor:
//   - 2-bit saturating counter encodings (SNT/WNT/WT/ST)
//   - PHT controller state encodings (INIT/RUN)
//   - sat_update(): saturating counter step toward taken / not-taken
// ---------------------------------------------------------------------------
package mor1kx_bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_cnt_e;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } pht_state_e;

    // Move the counter one step toward the resolved direction; clamp at the ends.
    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        if (taken)
            res = (cnt == ST) ? cnt : cnt + 2'b01;
        else
            res = (cnt == SNT) ? cnt : cnt - 2'b01;
        return res;
    endfunction

endpackage

// File: rtl/mor1kx_gshare_pht.sv
// ---------------------------------------------------------------------------
// mor1kx_gshare_pht
// Pattern history table of 2^GSHARE_BITS_NUM 2-bit saturating counters.
// After reset it walks every entry writing WNT, then enters RUN and accepts
// training writes (read-modify-write of one entry per cycle).
//
// Optional build macro: MOR1KX_GSHARE_BYPASS_EN
//   defined   - a lookup hitting the entry being trained this cycle returns
//               the updated counter value
//   undefined - the lookup returns the stored (pre-update) value
//
// Ports:
//   clk, rst      core clock, asynchronous active-low reset
//   rd_idx        lookup index
//   rd_cnt        counter at rd_idx (combinational)
//   train_en      training write this cycle (ignored unless RUN)
//   train_idx     entry to train
//   train_taken   resolved direction
//   init_done     high in RUN
// ---------------------------------------------------------------------------
module mor1kx_gshare_pht
    import mor1kx_bp_pkg::*;
#(
    parameter int GSHARE_BITS_NUM = 10
)
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [GSHARE_BITS_NUM-1:0] rd_idx,
    output logic [1:0]                 rd_cnt,
    input  logic                       train_en,
    input  logic [GSHARE_BITS_NUM-1:0] train_idx,
    input  logic                       train_taken,
    output logic                       init_done
);

    localparam int N     = GSHARE_BITS_NUM;
    localparam int DEPTH = 1 << N;
    localparam logic [N-1:0] PTR_ONE = {{(N-1){1'b0}}, 1'b1};

    logic [1:0]  pht_mem [DEPTH];

    pht_state_e  state, state_nxt;
    logic [N-1:0] ptr, ptr_nxt;

    logic        wr_en;
    logic [N-1:0] wr_idx;
    logic [1:0]  wr_data;
    logic [1:0]  upd_cnt;
    logic        do_train;

    assign do_train = train_en & (state == RUN);
    assign upd_cnt  = sat_update(pht_mem[train_idx], train_taken);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= INIT;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // Walk owns the write port during INIT; training owns it in RUN.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        wr_en     = 1'b0;
        wr_idx    = train_idx;
        wr_data   = upd_cnt;
        case (state)
            INIT: begin
                wr_en   = 1'b1;
                wr_idx  = ptr;
                wr_data = WNT;
                ptr_nxt = ptr + PTR_ONE;
                if (ptr == '1)
                    state_nxt = RUN;
            end
            RUN: begin
                wr_en = do_train;
            end
            default: begin
                state_nxt = INIT;
                ptr_nxt   = '0;
            end
        endcase
    end

    // Table contents are data: no reset, the walk initialises them.
    always_ff @(posedge clk) begin
        if (wr_en)
            pht_mem[wr_idx] <= wr_data;
    end

`ifdef MOR1KX_GSHARE_BYPASS_EN
    assign rd_cnt = (do_train && (rd_idx == train_idx)) ? upd_cnt : pht_mem[rd_idx];
`else
    assign rd_cnt = pht_mem[rd_idx];
`endif

    assign init_done = (state == RUN);

endmodule

// File: rtl/mor1kx_branch_predictor_gshare.sv
// ---------------------------------------------------------------------------
// mor1kx_branch_predictor_gshare
// Decode-stage gshare direction predictor for l.bf / l.bnf. The PHT index is
// brn_pc_i[N+1:2] XOR the global history register. The index of a decoded
// branch is saved and used to train that branch when it resolves one stage
// later.
//
// Optional build macro: MOR1KX_GSHARE_BYPASS_EN (see mor1kx_gshare_pht):
// a same-cycle lookup of the entry being trained sees the updated counter.
//
// Ports:
//   clk, rst            core clock, asynchronous active-low reset
//   op_bf_i, op_bnf_i   decode insn is l.bf / l.bnf
//   brn_pc_i            PC of the decode insn
//   padv_decode_i       decode advances this cycle
//   prev_op_brcond_i    insn in decode-execute is a conditional branch
//   execute_op_bf_i     resolving branch is l.bf
//   execute_op_bnf_i    resolving branch is l.bnf
//   flag_i              resolved SR[F]
//   predicted_flag_o    predicted flag for the decode insn
//   init_done_o         PHT walk complete
// ---------------------------------------------------------------------------
module mor1kx_branch_predictor_gshare
    import mor1kx_bp_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int GSHARE_BITS_NUM      = 10
)
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            op_bf_i,
    input  logic                            op_bnf_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] brn_pc_i,
    input  logic                            padv_decode_i,
    input  logic                            prev_op_brcond_i,
    input  logic                            execute_op_bf_i,
    input  logic                            execute_op_bnf_i,
    input  logic                            flag_i,
    output logic                            predicted_flag_o,
    output logic                            init_done_o
);

    localparam int N = GSHARE_BITS_NUM;

    logic [N-1:0] ghr;
    logic [N-1:0] saved_idx;
    logic [N-1:0] idx;
    logic [1:0]   rd_cnt;
    logic         taken;
    logic         real_taken;
    logic         train_req;
    logic         train_en;
    logic         capture;
    logic         unused_bits;

    assign idx        = brn_pc_i[N+1:2] ^ ghr;
    assign capture    = padv_decode_i & (op_bf_i | op_bnf_i);
    assign real_taken = execute_op_bf_i ? flag_i : ~flag_i;
    assign train_req  = prev_op_brcond_i & padv_decode_i;
    assign train_en   = train_req & init_done_o;

    // Only the low PHT-index PC bits and the counter MSB feed the prediction.
    assign unused_bits = ^{brn_pc_i, execute_op_bnf_i, rd_cnt[0]};

    mor1kx_gshare_pht #(
        .GSHARE_BITS_NUM (GSHARE_BITS_NUM)
    ) u_pht (
        .clk         (clk),
        .rst         (rst),
        .rd_idx      (idx),
        .rd_cnt      (rd_cnt),
        .train_en    (train_en),
        .train_idx   (saved_idx),
        .train_taken (real_taken),
        .init_done   (init_done_o)
    );

    // Decode -> execute boundary: index travels with the branch for training.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            saved_idx <= '0;
            ghr       <= '0;
        end else begin
            if (capture)
                saved_idx <= idx;
            if (train_en)
                ghr <= {ghr[N-2:0], real_taken};
        end
    end

    assign taken = init_done_o & rd_cnt[1];

    always_comb begin
        predicted_flag_o = 1'b0;
        if (op_bf_i)
            predicted_flag_o = taken;
        else if (op_bnf_i)
            predicted_flag_o = ~taken;
    end

endmodule

// File: tb/tb_mor1kx_branch_predictor_gshare.sv
// ---------------------------------------------------------------------------
// tb_mor1kx_branch_predictor_gshare
// Directed bench for the gshare predictor with GSHARE_BITS_NUM=4 (16-entry
// PHT). Hand-written sequences cover reset, the init walk and a mid-walk
// reset; a table of per-cycle vectors covers prediction, training,
// saturation, stalls and the same-entry lookup/update case.
// ---------------------------------------------------------------------------
module tb_mor1kx_branch_predictor_gshare;

    localparam int W = 32;
    localparam int N = 4;

`ifdef MOR1KX_GSHARE_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         op_bf_i;
    logic         op_bnf_i;
    logic [W-1:0] brn_pc_i;
    logic         padv_decode_i;
    logic         prev_op_brcond_i;
    logic         execute_op_bf_i;
    logic         execute_op_bnf_i;
    logic         flag_i;
    logic         predicted_flag_o;
    logic         init_done_o;

    always #5 clk = ~clk;

    mor1kx_branch_predictor_gshare #(
        .OPTION_OPERAND_WIDTH (W),
        .GSHARE_BITS_NUM      (N)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .op_bf_i          (op_bf_i),
        .op_bnf_i         (op_bnf_i),
        .brn_pc_i         (brn_pc_i),
        .padv_decode_i    (padv_decode_i),
        .prev_op_brcond_i (prev_op_brcond_i),
        .execute_op_bf_i  (execute_op_bf_i),
        .execute_op_bnf_i (execute_op_bnf_i),
        .flag_i           (flag_i),
        .predicted_flag_o (predicted_flag_o),
        .init_done_o      (init_done_o)
    );

    typedef struct packed {
        logic         bf;
        logic         bnf;
        logic [W-1:0] pc;
        logic         padv;
        logic         prev;
        logic         exbf;
        logic         exbnf;
        logic         flag;
        logic         exp_pred;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic bf, input logic bnf, input logic [W-1:0] pc,
                                input logic padv, input logic prev, input logic exbf,
                                input logic exbnf, input logic flag, input logic exp_pred);
        vec_t v;
        v.bf = bf; v.bnf = bnf; v.pc = pc; v.padv = padv; v.prev = prev;
        v.exbf = exbf; v.exbnf = exbnf; v.flag = flag; v.exp_pred = exp_pred;
        return v;
    endfunction

    task automatic check(input string nm, input logic act, input logic exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0b, expected %0b", nm, act, exp_v);
        end
    endtask

    task automatic drive(input vec_t v);
        op_bf_i          = v.bf;
        op_bnf_i         = v.bnf;
        brn_pc_i         = v.pc;
        padv_decode_i    = v.padv;
        prev_op_brcond_i = v.prev;
        execute_op_bf_i  = v.exbf;
        execute_op_bnf_i = v.exbnf;
        flag_i           = v.flag;
    endtask

    initial begin
        // Comments give PHT[0], GHR and saved index after each vector's edge.
        //                bf bnf pc     padv prv exbf exbnf flg exp
        tbl.push_back(mk(1, 0, 32'h40, 1, 0, 0, 0, 0, 0));   // idx0 P0=01 S=0
        tbl.push_back(mk(0, 0, 32'h00, 1, 1, 1, 0, 1, 0));   // P0=10 G=1
        tbl.push_back(mk(0, 0, 32'h00, 1, 1, 1, 0, 1, 0));   // P0=11 G=3
        tbl.push_back(mk(1, 0, 32'h4C, 1, 0, 0, 0, 0, 1));   // idx 3^3=0 -> taken
        tbl.push_back(mk(0, 1, 32'h4C, 1, 0, 0, 0, 0, 0));   // bnf inverts
        tbl.push_back(mk(1, 0, 32'h40, 1, 0, 0, 0, 0, 0));   // idx 3 untouched, S=3
        tbl.push_back(mk(0, 1, 32'h40, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 32'h4C, 1, 0, 0, 0, 0, 1));   // S=0
        tbl.push_back(mk(0, 0, 32'h00, 1, 1, 1, 0, 1, 0));   // P0 stays 11, G=7
        tbl.push_back(mk(0, 0, 32'h00, 1, 1, 0, 1, 0, 0));   // l.bnf flag0 = taken, G=F
        tbl.push_back(mk(0, 0, 32'h00, 1, 1, 1, 0, 1, 0));   // G=F
        tbl.push_back(mk(1, 0, 32'h3C, 1, 0, 0, 0, 0, 1));   // idx F^F=0, still 11
        tbl.push_back(mk(0, 0, 32'h00, 1, 1, 1, 0, 0, 0));   // P0=10 G=E
        tbl.push_back(mk(0, 0, 32'h00, 1, 1, 0, 1, 1, 0));   // l.bnf flag1 = not taken, P0=01 G=C
        tbl.push_back(mk(0, 0, 32'h00, 1, 1, 1, 0, 0, 0));   // P0=00 G=8
        tbl.push_back(mk(0, 0, 32'h00, 1, 1, 1, 0, 0, 0));   // P0=00 G=0
        tbl.push_back(mk(1, 0, 32'h40, 1, 0, 0, 0, 0, 0));   // idx0
        tbl.push_back(mk(0, 1, 32'h40, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 32'h00, 1, 1, 1, 0, 1, 0));   // P0=01 (not 00 wrapped) G=1
        tbl.push_back(mk(1, 0, 32'h44, 1, 0, 0, 0, 0, 0));   // idx 1^1=0 -> 01
        // stall: training requested but decode does not advance
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1, 0, 32'h44, 0, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 32'h00, 1, 1, 1, 0, 1, 0));   // single update P0=10 G=3
        tbl.push_back(mk(1, 0, 32'h4C, 1, 0, 0, 0, 0, 1));   // idx 0 -> 10
        tbl.push_back(mk(0, 0, 32'h00, 1, 1, 1, 0, 0, 0));   // P0=01 G=6
        tbl.push_back(mk(1, 0, 32'h58, 1, 0, 0, 0, 0, 0));   // idx 6^6=0 -> 01
        tbl.push_back(mk(1, 0, 32'h58, 1, 1, 1, 0, 1, BYP)); // lookup+train P0 same cycle
        tbl.push_back(mk(1, 0, 32'h34, 1, 0, 0, 0, 0, 1));   // G=D, idx 0 -> 10

        rst              = 1'b0;
        op_bf_i          = 1'b0;
        op_bnf_i         = 1'b0;
        brn_pc_i         = '0;
        padv_decode_i    = 1'b0;
        prev_op_brcond_i = 1'b0;
        execute_op_bf_i  = 1'b0;
        execute_op_bnf_i = 1'b0;
        flag_i           = 1'b0;

        #2;
        op_bf_i = 1'b1;
        #1;
        check("reset init_done", init_done_o, 1'b0);
        check("reset bf pred", predicted_flag_o, 1'b0);
        op_bf_i  = 1'b0;
        op_bnf_i = 1'b1;
        #1;
        check("reset bnf pred", predicted_flag_o, 1'b1);
        op_bnf_i = 1'b0;
        #1;
        check("reset nobranch pred", predicted_flag_o, 1'b0);

        @(posedge clk); #1;
        rst = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            check($sformatf("walk1 c%0d init_done", k), init_done_o, 1'b0);
        end

        // Walk pointer is 7 here; abort and restart the walk.
        rst = 1'b0;
        #1;
        check("midwalk rst init_done", init_done_o, 1'b0);
        op_bnf_i = 1'b1;
        #1;
        check("midwalk rst bnf pred", predicted_flag_o, 1'b1);
        op_bnf_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;

        op_bf_i = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            check($sformatf("walk2 c%0d init_done", k), init_done_o, (k == 16));
            if (k < 16)
                check($sformatf("walk2 c%0d bf pred", k), predicted_flag_o, 1'b0);
        end
        op_bf_i = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i]);
            @(negedge clk);
            check($sformatf("vec%0d pred", i), predicted_flag_o, tbl[i].exp_pred);
            @(posedge clk); #1;
        end

        check("final init_done", init_done_o, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
